// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, single-outstanding imem request FSM and a
// small circular queue of fetched {PC, instruction} pairs.
// Optional macro IFETCH_PERF_CNT_EN adds saturating pop/redirect counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction_Code,
    output logic [31:0] PC,
    output logic        valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] pcnt_fetch,
    output logic [31:0] pcnt_squash
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     req_addr_q;
    logic [31:0]     q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            issue, push, pop;

    assign valid     = (count_q != '0);
    assign imem_req  = (state_q == S_REQ) && (count_q < CW'(DEPTH)) && !redirect;
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;
    // A response that coincides with a redirect belongs to the squashed path.
    assign push      = (state_q == S_WAIT) && imem_rvalid && !redirect;
    assign pop       = valid && !stall && !redirect;

    assign Instruction_Code = valid ? q_instr[rd_ptr_q] : 32'd0;
    assign PC               = valid ? q_pc[rd_ptr_q]    : 32'd0;

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_REQ;
        else        state_q <= state_d;
    end

    // Fetch FSM next state; a redirect mid-WAIT must still swallow its response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:     if (issue) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)   state_d = S_REQ;
                else if (redirect) state_d = S_DISCARD;
            end
            S_DISCARD: if (imem_rvalid) state_d = S_REQ;
            default:   state_d = S_REQ;
        endcase
    end

    // Fetch PC and the address of the request currently in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            if (redirect)   fetch_pc_q <= redirect_pc;
            else if (issue) fetch_pc_q <= fetch_pc_q + 32'd4;
            if (issue)      req_addr_q <= fetch_pc_q;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Queue storage; contents are masked by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]    <= req_addr_q;
            q_instr[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] pcnt_fetch_q, pcnt_squash_q;

    // Saturating delivered-instruction and redirect counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_fetch_q  <= '0;
            pcnt_squash_q <= '0;
        end else begin
            if (pop && (pcnt_fetch_q != 32'hFFFF_FFFF))
                pcnt_fetch_q <= pcnt_fetch_q + 32'd1;
            if (redirect && (pcnt_squash_q != 32'hFFFF_FFFF))
                pcnt_squash_q <= pcnt_squash_q + 32'd1;
        end
    end

    assign pcnt_fetch  = pcnt_fetch_q;
    assign pcnt_squash = pcnt_squash_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, checked
// against a queue-based model of program-order delivery and a memory model.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Instruction_Code;
    logic [31:0] PC;
    logic        valid;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] pcnt_fetch;
    logic [31:0] pcnt_squash;
`endif

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .Instruction_Code (Instruction_Code),
        .PC               (PC),
        .valid            (valid)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .pcnt_fetch       (pcnt_fetch),
        .pcnt_squash      (pcnt_squash)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    ent_t        mq[$];
    logic [31:0] model_fpc;
    bit          pend_v, pend_sq;
    logic [31:0] pend_addr;
    int          pend_lat;
    int          gnt_pct = 100;
    int          lat_lo = 0, lat_hi = 0;
    bit          last_issue;
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];
    logic [31:0] iss_addr[$];
    int          iss_cyc[$];
    int          total_pops = 0;
    logic [31:0] m_fetch, m_squash;
    int          t;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (pop_pc.size() > i) ? pop_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int pcyc_at(input int i);
        return (pop_cyc.size() > i) ? pop_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] iss_at(input int i);
        return (iss_addr.size() > i) ? iss_addr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        pop_pc.delete(); pop_cyc.delete(); iss_addr.delete(); iss_cyc.delete();
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
        bit          exp_valid, exp_req, issued, accepted, resp;
        logic [31:0] resp_addr;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        resp        = 1'b0;
        resp_addr   = 32'h0;
        if (pend_v && pend_lat == 0) begin
            resp        = 1'b1;
            resp_addr   = pend_addr;
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend_v) pend_lat--;
        end
        @(negedge clk);
        exp_valid = (mq.size() != 0);
        exp_req   = !pend_v && (mq.size() < DEPTH) && !rd;
        check("valid", 32'(valid), 32'(exp_valid));
        check("pc", PC, exp_valid ? mq[0].pc : 32'h0);
        check("instr", Instruction_Code, exp_valid ? mq[0].ins : 32'h0);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, model_fpc);
`ifdef IFETCH_PERF_CNT_EN
        check("pcnt_fetch", pcnt_fetch, m_fetch);
        check("pcnt_squash", pcnt_squash, m_squash);
`endif
        issued   = exp_req && imem_gnt;
        accepted = resp && !pend_sq && !rd;
        if (resp) pend_v = 1'b0;
        if (exp_valid && !st && !rd) begin
            pop_pc.push_back(mq[0].pc);
            pop_cyc.push_back(cyc);
            void'(mq.pop_front());
            total_pops++;
            m_fetch++;
        end
        if (accepted) begin
            mq.push_back('{pc: resp_addr, ins: mem_data(resp_addr)});
            check("no_overflow", 32'(mq.size() <= DEPTH), 32'd1);
        end
        if (rd) begin
            mq.delete();
            model_fpc = rpc;
            if (pend_v) pend_sq = 1'b1;
            m_squash++;
        end
        last_issue = issued;
        if (issued) begin
            pend_v    = 1'b1;
            pend_sq   = 1'b0;
            pend_addr = model_fpc;
            pend_lat  = $urandom_range(lat_hi, lat_lo);
            iss_addr.push_back(model_fpc);
            iss_cyc.push_back(cyc);
            model_fpc = model_fpc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One-cycle asynchronous reset pulse; memory model is reset alongside.
    task automatic reset_pulse();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        pend_v      = 1'b0;
        pend_sq     = 1'b0;
        mq.delete();
        model_fpc   = RESET_PC;
        m_fetch     = 32'h0;
        m_squash    = 32'h0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", Instruction_Code, 32'h0);
        check("rst_pc", PC, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_pcnt_fetch", pcnt_fetch, 32'h0);
        check("rst_pcnt_squash", pcnt_squash, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_req", 32'(imem_req), 32'd1);
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        pend_v = 1'b0; pend_sq = 1'b0; pend_addr = 32'h0; pend_lat = 0;
        model_fpc = RESET_PC; m_fetch = 32'h0; m_squash = 32'h0; last_issue = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        // Immediate grant, one-cycle response: one beat every 2 cycles.
        gnt_pct = 100; lat_lo = 0; lat_hi = 0;
        clear_logs();
        repeat (6) cycle(0, 0, 32'h0);
        check("t1_pc0", pop_at(0), 32'h0);
        check("t1_pc1", pop_at(1), 32'h4);
        check("t1_spacing", 32'(pcyc_at(1) - pcyc_at(0)), 32'd2);

        // Stall holds PC 0x8 at head while the queue fills and requests stop.
        repeat (10) cycle(1, 0, 32'h0);
        check("t2_req_full", 32'(imem_req), 32'd0);
        check("t2_head", PC, 32'h8);
        repeat (4) cycle(0, 0, 32'h0);
        check("t2_drain0", pop_at(2), 32'h8);
        check("t2_drain1", pop_at(3), 32'hC);

        // Redirect in WAIT; response two cycles later is dropped.
        lat_lo = 2; lat_hi = 2;
        last_issue = 1'b0;
        for (int i = 0; i < 20 && !last_issue; i++) cycle(0, 0, 32'h0);
        check("t3_issue_seen", 32'(last_issue), 32'd1);
        t = cyc;
        clear_logs();
        cycle(0, 1, 32'h100);
        for (int i = 0; i < 30 && pop_pc.size() == 0; i++) cycle(0, 0, 32'h0);
        check("t3_first_addr", iss_at(0), 32'h100);
        check("t3_issue_cycle", 32'((iss_cyc.size() > 0) ? iss_cyc[0] : -1), 32'(t + 3));
        check("t3_first_pc", pop_at(0), 32'h100);

        // Redirect coinciding with the response: dropped, no DISCARD.
        lat_lo = 0; lat_hi = 0;
        last_issue = 1'b0;
        for (int i = 0; i < 20 && !last_issue; i++) cycle(0, 0, 32'h0);
        check("t4_issue_seen", 32'(last_issue), 32'd1);
        cycle(0, 1, 32'h200);
        check("t4_valid_after", 32'(valid), 32'd0);
        clear_logs();
        cycle(0, 0, 32'h0);
        check("t4_issue_now", 32'(iss_addr.size()), 32'd1);
        check("t4_addr", iss_at(0), 32'h200);

        // Reset pulse while a request is outstanding with a queued entry.
        lat_lo = 5; lat_hi = 5;
        for (int i = 0; i < 40 && !(mq.size() >= 1 && pend_v); i++) cycle(1, 0, 32'h0);
        check("t5_setup", 32'(mq.size() >= 1 && pend_v), 32'd1);
        reset_pulse();

        // Fetch PC wraps past the top of the address space.
        lat_lo = 0; lat_hi = 0;
        clear_logs();
        cycle(0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && pop_pc.size() < 2; i++) cycle(0, 0, 32'h0);
        check("t6_wrap0", pop_at(0), 32'hFFFF_FFFC);
        check("t6_wrap1", pop_at(1), 32'h0000_0000);

        // Random traffic: grants, latencies, stalls, redirects, rare resets.
        gnt_pct = 60; lat_lo = 0; lat_hi = 3;
        total_pops = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            if ($urandom_range(499) == 0) begin
                reset_pulse();
            end else begin
                rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4)
                                               : ($urandom & 32'hFFFF_FFFC);
                cycle($urandom_range(99) < 30, $urandom_range(99) < 4, rpc);
            end
        end
        check("progress", 32'(total_pops > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
